// File: rtl/mean_compens_ctrl.sv
// Gear-shift controller for mean_compens_v2: steps tau_rc up as the residual mean settles, flags lock.
// Optional MEAN_CTRL_FREEZE_EN adds a freeze input and a comp_hold output.
module mean_compens_ctrl #(
   parameter int unsigned WIDTH      = 14,
   parameter int unsigned WIN_N      = 10,
   parameter int unsigned TAU_MIN    = 4,
   parameter int unsigned TAU_MAX    = 15,
   parameter int unsigned LOCK_THR   = 4,
   parameter int unsigned UNLOCK_THR = 64,
   parameter int unsigned LOCK_WIN   = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] data_in,
   input  logic                    valid_in,
`ifdef MEAN_CTRL_FREEZE_EN
   input  logic                    freeze,
   output logic                    comp_hold,
`endif
   output logic [4:0]              tau_rc,
   output logic                    comp_clr,
   output logic                    locked,
   output logic [1:0]              state,
   output logic signed [WIDTH-1:0] win_mean,
   output logic [7:0]              relock_cnt
);

   localparam int unsigned AW = WIDTH + WIN_N;
   localparam int unsigned GW = $clog2(LOCK_WIN + 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StClear = 2'd1,
      StAcq   = 2'd2,
      StTrack = 2'd3
   } state_e;

   state_e                  r_state;
   state_e                  w_state_nxt;

   logic signed [AW-1:0]    r_acc;
   logic signed [AW-1:0]    r_sum;
   logic signed [AW-1:0]    w_acc_nxt;
   logic [WIN_N-1:0]        r_cnt;
   logic                    r_pend;
   logic [4:0]              r_tau;
   logic [GW-1:0]           r_good;
   logic [GW-1:0]           w_good_inc;
   logic signed [WIDTH-1:0] r_mean;
   logic signed [WIDTH-1:0] w_mean;
   logic signed [WIDTH:0]   w_mean_x;
   logic [WIDTH:0]          w_abs;
   logic [7:0]              r_relock;

   logic w_active;
   logic w_frz;
   logic w_done;
   logic w_last;
   logic w_good_win;
   logic w_unlock;
   logic w_tau_top;
   logic w_lock_hit;

   assign w_active = (r_state == StAcq) || (r_state == StTrack);

`ifdef MEAN_CTRL_FREEZE_EN
   assign w_frz = freeze & w_active;
`else
   assign w_frz = 1'b0;
`endif

   // A completed window is evaluated the cycle after its last sample; freeze defers it.
   assign w_done    = r_pend & w_active & ~w_frz;
   assign w_acc_nxt = r_acc + AW'(data_in);
   assign w_last    = w_active & ~w_frz & valid_in & (r_cnt == '1);

   // Magnitude in WIDTH+1 bits so the most negative mean does not wrap.
   assign w_mean     = WIDTH'(r_sum >>> WIN_N);
   assign w_mean_x   = {w_mean[WIDTH-1], w_mean};
   assign w_abs      = w_mean_x[WIDTH] ? -w_mean_x : w_mean_x;
   assign w_good_win = w_abs <= (WIDTH+1)'(LOCK_THR);
   assign w_unlock   = w_abs > (WIDTH+1)'(UNLOCK_THR);
   assign w_tau_top  = r_tau >= 5'(TAU_MAX);
   assign w_good_inc = r_good + 1'b1;
   assign w_lock_hit = w_good_inc == GW'(LOCK_WIN);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = StClear;
      end else begin
         unique case (r_state)
            StIdle:  w_state_nxt = StIdle;
            StClear: w_state_nxt = StAcq;
            StAcq: begin
               if (w_done && w_good_win && w_tau_top && w_lock_hit) begin
                  w_state_nxt = StTrack;
               end
            end
            StTrack: begin
               if (w_done && w_unlock) begin
                  w_state_nxt = StClear;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_comb begin
      comp_clr   = (r_state == StClear);
      locked     = (r_state == StTrack);
      state      = r_state;
      tau_rc     = r_tau;
      win_mean   = r_mean;
      relock_cnt = r_relock;
`ifdef MEAN_CTRL_FREEZE_EN
      comp_hold  = w_frz;
`endif
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_acc    <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_pend   <= 1'b0;
         r_tau    <= 5'(TAU_MIN);
         r_good   <= '0;
         r_mean   <= '0;
         r_relock <= '0;
      end else begin
         if (!w_active) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
         end else begin
            if (w_done) begin
               r_pend <= 1'b0;
            end
            if (!w_frz && valid_in) begin
               if (w_last) begin
                  r_sum  <= w_acc_nxt;
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_pend <= 1'b1;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         if (r_state == StClear) begin
            r_tau  <= 5'(TAU_MIN);
            r_good <= '0;
         end

         if (w_done) begin
            r_mean <= w_mean;
         end

         // A coincident start discards the window's effect on tau and lock progress.
         if (w_done && !start) begin
            if (r_state == StAcq) begin
               if (!w_good_win) begin
                  r_good <= '0;
               end else if (!w_tau_top) begin
                  r_tau  <= r_tau + 5'd1;
                  r_good <= '0;
               end else begin
                  r_good <= w_good_inc;
               end
            end else if (w_unlock && (r_relock != 8'hFF)) begin
               r_relock <= r_relock + 8'd1;
            end
         end
      end
   end

endmodule
